shift_frame_serializer: RTL and testbench
=========================================

# shift_frame_serializer

Parallel-to-serial front end that feeds the bidirectional shift register. It accepts an N-bit word over a valid/ready handshake and emits it one bit per clock. Each bit comes with the direction control the downstream register needs. After N shifts, the downstream register holds the word in its original bit order, in either direction. It sits directly upstream of the shift register: `ser_data` drives its `input_data` and `ser_dir` drives its `dir`.

## Interface
- `N`, 4: word width in bits; must be ≥ 2.
- `GAP`, 1: idle cycles inserted after each frame; 0 is allowed.

- `CLK`  input  1  rising-edge clock.
- `RST`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream has a word on `in_data`/`in_dir`.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  N  word to serialize.
- `in_dir`  input  1  1 = downstream right shift (LSB sent first); 0 = left shift (MSB sent first).
- `ser_data`  output  1  serial bit, registered.
- `ser_dir`  output  1  direction for downstream `dir`, registered.
- `ser_en`  output  1  high on cycles where `ser_data` is a valid shift bit.
- `frame_done`  output  1  one-cycle pulse coinciding with the last bit of a frame.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE → SHIFT on handshake (`in_valid && in_ready`).
  - SHIFT → (PARITY if enabled) → GAP if `GAP>0`, else → IDLE.
  - GAP → IDLE after `GAP` cycles.
- `in_ready` = (state == IDLE) && !RST. It is decoded from the state register, with no combinational path from `in_valid`.
- On handshake, the block latches `in_data` into a shadow register and `in_dir` into `dir_q`. `in_data` may change freely afterwards.
- Bit order:
  - `dir_q=1`: sends `in_data[0]`, `[1]`, …, `[N-1]`. The downstream right shift lands bit 0 at the LSB.
  - `dir_q=0`: sends `[N-1]` down to `[0]`.
- A bit counter of width $clog2(N+1) counts 0..N-1 in SHIFT and wraps to 0 on exit.
- `ser_dir` = `dir_q`. It is held through SHIFT/PARITY/GAP and retains its last value in IDLE.
- `ser_data` retains its last value when `ser_en=0`. The downstream register must only be clocked or considered when `ser_en=1`.
- `in_valid` while not ready: ignored. The word is not consumed, and upstream must hold it.
- Reset values:
  - state IDLE, counter 0.
  - `ser_data`=0, `ser_dir`=0, `ser_en`=0, `frame_done`=0, `busy`=0.
  - `in_ready`=0 while `RST` is high.
- `RST` mid-frame: the frame is aborted at that edge. `ser_en`/`frame_done` are 0 from the next cycle, no `frame_done` is emitted for the aborted frame, and the shadow word is discarded.

## Timing
- Handshake at edge k: bits appear on `ser_data` with `ser_en=1` during cycles k+1 … k+N.
- `frame_done` is high during cycle k+N (or k+N+1 with parity).
- GAP occupies the following `GAP` cycles with `ser_en=0`. `in_ready` returns high in the next cycle.
- Frame period: N + GAP + 1 cycles (plus 1 with parity).
- With `GAP=0` and `in_valid` held, words stream with exactly one idle (`ser_en=0`) cycle between frames.
- `busy` rises the cycle after the handshake and falls the cycle `in_ready` rises.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - A PARITY state follows SHIFT and emits one extra bit with `ser_en=1`. The bit is even parity: XOR of all N data bits.
  - `frame_done` moves to the parity cycle.
  - The downstream register must be instantiated N+1 wide.
- Not defined: no PARITY state exists, and frames are exactly N bits.

## Test plan
- N=4, GAP=1. Reset 2 cycles, then `in_data`=4'b1011, `in_dir`=1 → `ser_data` 1,1,0,1 on cycles 1-4, `ser_dir`=1, `frame_done` on cycle 4. The downstream register reads 4'b1011 after cycle 4, and `in_ready` is high on cycle 6.
- Same word, `in_dir`=0 → `ser_data` 1,0,1,1, `ser_dir`=0, downstream register reads 4'b1011.
- GAP=0, `in_valid` held with 4'hA then 4'h5 (dir=1) → bits 0,1,0,1 then one `ser_en=0` cycle then 1,0,1,0. Two `frame_done` pulses, 5 cycles apart.
- `RST` asserted at cycle 2 of a frame → `ser_en`=0 and `busy`=0 next cycle, no `frame_done`, `in_ready`=1 the cycle after `RST` falls.
- `in_valid` toggled during SHIFT with different data → ignored. The in-flight frame is unchanged, and the new word is accepted only once `in_ready`=1.
- `SERIALIZER_PARITY_EN`, word 4'b1011 dir=1 → 1,1,0,1 then parity bit 1, `frame_done` on cycle 5.

Source files
------------

// File: rtl/shift_frame_serializer.sv
// ---------------------------------------------------------------------------
// shift_frame_serializer
//
// Parallel-to-serial front end for a bidirectional shift register. A word of
// N bits is accepted over a valid/ready handshake. It is then sent one bit per
// clock on ser_data, and ser_dir gives the direction the downstream register
// must shift in. After a full frame, the downstream register holds the word
// in its original bit order.
//
// Optional feature macro: SERIALIZER_PARITY_EN
//   When this macro is defined, one even-parity bit follows the data bits. The
//   downstream register must then be N+1 bits wide.
//
// Parameters
//   N    word width in bits (>= 2)
//   GAP  idle cycles after each frame (0 allowed)
//
// Ports
//   CLK         rising-edge clock
//   RST         synchronous active-high reset
//   in_valid    upstream word present on in_data / in_dir
//   in_ready    block can accept a word this cycle
//   in_data     word to serialize
//   in_dir      1 = right shift downstream (LSB first), 0 = left (MSB first)
//   ser_data    serial bit (registered, holds when ser_en = 0)
//   ser_dir     downstream direction (registered)
//   ser_en      ser_data carries a valid shift bit this cycle
//   frame_done  one-cycle pulse on the last bit of a frame
//   busy        block is not idle
// ---------------------------------------------------------------------------
module shift_frame_serializer #(
    parameter int N   = 4,
    parameter int GAP = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_dir,
    output logic         ser_data,
    output logic         ser_dir,
    output logic         ser_en,
    output logic         frame_done,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam bit HAS_GAP = (GAP > 0);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic            dir_q, dir_d;
    logic            data_q, data_d;
    logic            en_q, en_d;
    logic            done_q, done_d;
    logic            handshake_s;

    // Bit sent at position pos of the frame, for the given direction.
    function automatic logic bit_at(input logic [N-1:0] w, input logic d,
                                    input logic [CW-1:0] pos);
        logic [N-1:0] t;
        int           idx;
        idx = d ? int'(pos) : (N - 1 - int'(pos));
        t   = w >> idx;
        return t[0];
    endfunction

    // Even parity over all data bits.
    function automatic logic even_parity(input logic [N-1:0] w);
        return ^w;
    endfunction

    assign in_ready    = (state_q == ST_IDLE) && !RST;
    assign handshake_s = in_valid && in_ready;

    assign ser_data    = data_q;
    assign ser_dir     = dir_q;
    assign ser_en      = en_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != ST_IDLE);

    // Next-state and next-output computation.
    // Outputs are computed one edge early, so the bit for a given cycle is
    // already registered when that cycle begins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        data_d   = data_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = {CW{1'b0}};
                    shadow_d = in_data;
                    dir_d    = in_dir;
                    data_d   = bit_at(in_data, in_dir, {CW{1'b0}});
                    en_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d = {CW{1'b0}};
`ifdef SERIALIZER_PARITY_EN
                    state_d = ST_PARITY;
                    data_d  = even_parity(shadow_q);
                    en_d    = 1'b1;
                    done_d  = 1'b1;
`else
                    gap_d = {GW{1'b0}};
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    data_d = bit_at(shadow_q, dir_q, cnt_d);
                    en_d   = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    done_d = 1'b0;
`else
                    // The pulse lands on the cycle that carries the last data bit.
                    done_d = (cnt_q == CW'(N - 2));
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                gap_d = {GW{1'b0}};
                if (HAS_GAP) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    gap_d   = {GW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                gap_d   = {GW{1'b0}};
            end
        endcase
    end

    // State and output registers. Reset aborts any frame and drops the shadow word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            gap_q    <= {GW{1'b0}};
            shadow_q <= {N{1'b0}};
            dir_q    <= 1'b0;
            data_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            data_q   <= data_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_frame_serializer.sv
// Testbench for shift_frame_serializer: two instances (GAP=1 and GAP=0) share
// stimulus. A timeline model predicts every output cycle by cycle.
module tb_shift_frame_serializer;

    localparam int N    = 4;
    localparam int MAXC = 1024;
    localparam int NC   = 700;
`ifdef SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = N + P;
    localparam int W  = N + P;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         in_dir;
    logic [N-1:0] in_data;
    logic [1:0]   rdy, sd, sdir, sen, fd, bsy;

    always #5 CLK = ~CLK;

    shift_frame_serializer #(.N(N), .GAP(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_dir(in_dir), .ser_data(sd[0]), .ser_dir(sdir[0]),
        .ser_en(sen[0]), .frame_done(fd[0]), .busy(bsy[0])
    );

    shift_frame_serializer #(.N(N), .GAP(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_dir(in_dir), .ser_data(sd[1]), .ser_dir(sdir[1]),
        .ser_en(sen[1]), .frame_done(fd[1]), .busy(bsy[1])
    );

    int n_total = 0;
    int n_bad   = 0;

    // Expected outputs per instance per cycle.
    bit           e_en   [2][MAXC];
    bit           e_data [2][MAXC];
    bit           e_dir  [2][MAXC];
    bit           e_done [2][MAXC];
    bit           e_busy [2][MAXC];
    logic [W-1:0] e_word [2][MAXC];
    int           free_c [2];
    logic [W-1:0] dreg   [2];

    // Stimulus table.
    bit           st_rst  [MAXC];
    bit           st_val  [MAXC];
    bit           st_dir  [MAXC];
    logic [N-1:0] st_data [MAXC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Record a frame accepted by instance i at the edge ending cycle t.
    task automatic schedule(input int i, input int t, input logic [N-1:0] w, input logic d);
        logic [W-1:0] ew;
        bit           b;
        int           cyc;
        for (int k = 0; k < N; k++) begin
            b   = d ? w[k] : w[N-1-k];
            cyc = t + 1 + k;
            for (int c = cyc; c < MAXC; c++) e_data[i][c] = b;
            e_en[i][cyc] = 1'b1;
        end
        if (P == 1) begin
            cyc = t + 1 + N;
            for (int c = cyc; c < MAXC; c++) e_data[i][c] = ^w;
            e_en[i][cyc] = 1'b1;
        end
        e_done[i][t + FL] = 1'b1;
        for (int c = t + 1; c <= t + FL + gap_of(i); c++) e_busy[i][c] = 1'b1;
        for (int c = t + 1; c < MAXC; c++) e_dir[i][c] = d;
        ew = W'(w);
        if (P == 1) ew = d ? (ew | (W'(^w) << N)) : ((ew << 1) | W'(^w));
        e_word[i][t + FL] = ew;
        free_c[i] = t + FL + gap_of(i) + 1;
    endtask

    // Reset during cycle t zeroes all outputs from cycle t+1 onwards.
    task automatic apply_reset(input int i, input int t);
        for (int c = t + 1; c < MAXC; c++) begin
            e_en[i][c]   = 1'b0;
            e_data[i][c] = 1'b0;
            e_dir[i][c]  = 1'b0;
            e_done[i][c] = 1'b0;
            e_busy[i][c] = 1'b0;
        end
        free_c[i] = t + 1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            free_c[i] = 0;
            dreg[i]   = '0;
            for (int c = 0; c < MAXC; c++) begin
                e_en[i][c] = 1'b0; e_data[i][c] = 1'b0; e_dir[i][c] = 1'b0;
                e_done[i][c] = 1'b0; e_busy[i][c] = 1'b0; e_word[i][c] = '0;
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            st_rst[c] = 1'b0; st_val[c] = 1'b0; st_dir[c] = 1'b0; st_data[c] = '0;
        end
        // Directed prefix.
        st_rst[0] = 1'b1;
        st_val[1] = 1'b1; st_data[1] = 4'b1011; st_dir[1] = 1'b1;
        st_val[8] = 1'b1; st_data[8] = 4'b1011; st_dir[8] = 1'b0;
        for (int c = 15; c <= 30; c++) begin
            st_val[c]  = 1'b1;
            st_dir[c]  = 1'b1;
            st_data[c] = (c < 20) ? 4'hA : 4'h5;
        end
        st_val[34] = 1'b1; st_data[34] = 4'b0110; st_dir[34] = 1'b0;
        st_rst[36] = 1'b1; st_rst[37] = 1'b1;
        st_val[38] = 1'b1; st_data[38] = 4'b1001; st_dir[38] = 1'b1;
        // Randomized remainder.
        for (int c = 39; c < NC; c++) begin
            st_rst[c]  = ($urandom_range(0, 49) == 0);
            st_val[c]  = ($urandom_range(0, 1) == 1);
            st_dir[c]  = ($urandom_range(0, 1) == 1);
            st_data[c] = N'($urandom);
        end

        RST = 1'b1; in_valid = 1'b0; in_dir = 1'b0; in_data = '0;
        repeat (2) @(posedge CLK);

        for (int t = 0; t < NC; t++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("en[%0d]@%0d", i, t),   32'(sen[i]),  32'(e_en[i][t]));
                check($sformatf("data[%0d]@%0d", i, t), 32'(sd[i]),   32'(e_data[i][t]));
                check($sformatf("dir[%0d]@%0d", i, t),  32'(sdir[i]), 32'(e_dir[i][t]));
                check($sformatf("done[%0d]@%0d", i, t), 32'(fd[i]),   32'(e_done[i][t]));
                check($sformatf("busy[%0d]@%0d", i, t), 32'(bsy[i]),  32'(e_busy[i][t]));
                // Downstream register driven by the serial stream.
                if (sen[i] === 1'b1) begin
                    if (sdir[i] === 1'b1) dreg[i] = {sd[i], dreg[i][W-1:1]};
                    else                  dreg[i] = {dreg[i][W-2:0], sd[i]};
                end
                if (e_done[i][t])
                    check($sformatf("word[%0d]@%0d", i, t), 32'(dreg[i]), 32'(e_word[i][t]));
            end
            RST      = st_rst[t];
            in_valid = st_val[t];
            in_dir   = st_dir[t];
            in_data  = st_data[t];
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("ready[%0d]@%0d", i, t), 32'(rdy[i]),
                      32'(!st_rst[t] && (t >= free_c[i])));
                if (st_rst[t]) apply_reset(i, t);
                else if (st_val[t] && (t >= free_c[i])) schedule(i, t, st_data[t], st_dir[t]);
            end
            @(posedge CLK);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
